hetic_nest_ctrl: RTL and testbench

- Sits directly downstream of the HETIC interrupt controller and arbiter, between the controller and the core's trap interface.
- Qualifies the arbitrated winner (valid/id/level/heti/nest) against the currently running interrupt level and the nesting permission.
- Offers the qualified interrupt to the core with a valid/ready handshake, returns a one-cycle claim acknowledge (id + ack) to the controller, and maintains a hardware level stack popped on mret.

---
 rtl/hetic_nest_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_hetic_nest_ctrl.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hetic_nest_ctrl.sv
// Nesting controller between the HETIC arbiter and the core trap interface.
// Optional software threshold input enabled by defining HETIC_NEST_CTRL_THRESH_EN.
module hetic_nest_ctrl #(
  parameter int NrIrqLines  = 64,
  parameter int NrIrqPrios  = 32,
  parameter int StackDepth  = 4,
  localparam int IrqWidth   = $clog2(NrIrqLines),
  localparam int PrioWidth  = $clog2(NrIrqPrios),
  localparam int DepthWidth = $clog2(StackDepth + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  irq_valid_i,
  input  logic [IrqWidth-1:0]   irq_id_i,
  input  logic [PrioWidth-1:0]  irq_level_i,
  input  logic                  irq_heti_i,
  input  logic                  irq_nest_i,
`ifdef HETIC_NEST_CTRL_THRESH_EN
  input  logic [PrioWidth-1:0]  thresh_i,
`endif
  output logic                  irq_ack_o,
  output logic [IrqWidth-1:0]   irq_ack_id_o,
  output logic                  core_irq_valid_o,
  output logic [IrqWidth-1:0]   core_irq_id_o,
  output logic                  core_irq_heti_o,
  output logic [PrioWidth-1:0]  core_irq_level_o,
  input  logic                  core_irq_ready_i,
  input  logic                  core_mret_i,
  output logic [PrioWidth-1:0]  cur_level_o,
  output logic [DepthWidth-1:0] depth_o,
  output logic                  err_o
);

  typedef enum logic [1:0] {
    StIdle,
    StOffer,
    StAck
  } state_e;

  typedef struct packed {
    logic [PrioWidth-1:0] level;
    logic                 nest;
  } frame_t;

  localparam logic [DepthWidth-1:0] MaxDepth = DepthWidth'(StackDepth);
  localparam logic [DepthWidth-1:0] OneDepth = DepthWidth'(1);

  state_e                state_q, state_d;
  logic [IrqWidth-1:0]   offer_id_q, offer_id_d;
  logic [PrioWidth-1:0]  offer_level_q, offer_level_d;
  logic                  offer_heti_q, offer_heti_d;
  logic                  offer_nest_q, offer_nest_d;
  logic                  valid_q, valid_d;
  logic                  ack_q, ack_d;
  logic [IrqWidth-1:0]   ack_id_q, ack_id_d;
  logic [PrioWidth-1:0]  cur_level_q, cur_level_d;
  logic                  cur_nest_q, cur_nest_d;
  logic [DepthWidth-1:0] depth_q, depth_d;
  logic                  err_q, err_d;
  frame_t                stack_q [StackDepth];
  frame_t                stack_d [StackDepth];

  logic push;
  logic level_ok;
  logic thresh_ok;
  logic room_ok;
  logic qualify;

  assign level_ok = irq_level_i > cur_level_q;
`ifdef HETIC_NEST_CTRL_THRESH_EN
  assign thresh_ok = irq_level_i > thresh_i;
`else
  assign thresh_ok = 1'b1;
`endif
  // A non-nestable handler blocks everything until its mret.
  assign room_ok = (depth_q == '0) | (cur_nest_q & (depth_q < MaxDepth));
  assign qualify = irq_valid_i & level_ok & thresh_ok & room_ok;

  always_comb begin
    state_d       = state_q;
    offer_id_d    = offer_id_q;
    offer_level_d = offer_level_q;
    offer_heti_d  = offer_heti_q;
    offer_nest_d  = offer_nest_q;
    valid_d       = valid_q;
    ack_d         = 1'b0;
    ack_id_d      = ack_id_q;
    cur_level_d   = cur_level_q;
    cur_nest_d    = cur_nest_q;
    depth_d       = depth_q;
    err_d         = err_q;
    stack_d       = stack_q;
    push          = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (qualify) begin
          offer_id_d    = irq_id_i;
          offer_level_d = irq_level_i;
          offer_heti_d  = irq_heti_i;
          offer_nest_d  = irq_nest_i;
          valid_d       = 1'b1;
          state_d       = StOffer;
        end
      end
      StOffer: begin
        if (core_irq_ready_i) begin
          push     = 1'b1;
          valid_d  = 1'b0;
          ack_d    = 1'b1;
          ack_id_d = offer_id_q;
          state_d  = StAck;
        end
      end
      StAck: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Pop before push so a same-cycle mret+accept re-pushes the popped frame.
    if (core_mret_i) begin
      if (depth_d != '0) begin
        depth_d = depth_d - OneDepth;
        for (int i = 0; i < StackDepth; i++) begin
          if (i == int'(depth_d)) begin
            cur_level_d = stack_q[i].level;
            cur_nest_d  = stack_q[i].nest;
          end
        end
      end else begin
        err_d = 1'b1;
      end
    end

    if (push) begin
      if (depth_d == MaxDepth) begin
        err_d = 1'b1;
      end else begin
        for (int i = 0; i < StackDepth; i++) begin
          if (i == int'(depth_d)) begin
            stack_d[i].level = cur_level_d;
            stack_d[i].nest  = cur_nest_d;
          end
        end
        depth_d     = depth_d + OneDepth;
        cur_level_d = offer_level_q;
        cur_nest_d  = offer_nest_q;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      offer_id_q    <= '0;
      offer_level_q <= '0;
      offer_heti_q  <= 1'b0;
      offer_nest_q  <= 1'b0;
      valid_q       <= 1'b0;
      ack_q         <= 1'b0;
      ack_id_q      <= '0;
      cur_level_q   <= '0;
      cur_nest_q    <= 1'b0;
      depth_q       <= '0;
      err_q         <= 1'b0;
      for (int i = 0; i < StackDepth; i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      offer_id_q    <= offer_id_d;
      offer_level_q <= offer_level_d;
      offer_heti_q  <= offer_heti_d;
      offer_nest_q  <= offer_nest_d;
      valid_q       <= valid_d;
      ack_q         <= ack_d;
      ack_id_q      <= ack_id_d;
      cur_level_q   <= cur_level_d;
      cur_nest_q    <= cur_nest_d;
      depth_q       <= depth_d;
      err_q         <= err_d;
      stack_q       <= stack_d;
    end
  end

  assign irq_ack_o        = ack_q;
  assign irq_ack_id_o     = ack_id_q;
  assign core_irq_valid_o = valid_q;
  assign core_irq_id_o    = offer_id_q;
  assign core_irq_heti_o  = offer_heti_q;
  assign core_irq_level_o = offer_level_q;
  assign cur_level_o      = cur_level_q;
  assign depth_o          = depth_q;
  assign err_o            = err_q;

endmodule

// File: tb/tb_hetic_nest_ctrl.sv
// Scoreboard bench for hetic_nest_ctrl: directed scenarios plus random traffic
// checked against a queue-based nesting model.
module tb_hetic_nest_ctrl;

  localparam int NrIrqLines = 64;
  localparam int NrIrqPrios = 32;
  localparam int StackDepth = 4;
  localparam int IW = 6;
  localparam int PW = 5;
  localparam int DW = 3;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          irq_valid_i = 1'b0;
  logic [IW-1:0] irq_id_i = '0;
  logic [PW-1:0] irq_level_i = '0;
  logic          irq_heti_i = 1'b0;
  logic          irq_nest_i = 1'b0;
`ifdef HETIC_NEST_CTRL_THRESH_EN
  logic [PW-1:0] thresh_i = '0;
`endif
  logic          irq_ack_o;
  logic [IW-1:0] irq_ack_id_o;
  logic          core_irq_valid_o;
  logic [IW-1:0] core_irq_id_o;
  logic          core_irq_heti_o;
  logic [PW-1:0] core_irq_level_o;
  logic          core_irq_ready_i = 1'b0;
  logic          core_mret_i = 1'b0;
  logic [PW-1:0] cur_level_o;
  logic [DW-1:0] depth_o;
  logic          err_o;

  hetic_nest_ctrl #(
    .NrIrqLines(NrIrqLines),
    .NrIrqPrios(NrIrqPrios),
    .StackDepth(StackDepth)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .irq_valid_i     (irq_valid_i),
    .irq_id_i        (irq_id_i),
    .irq_level_i     (irq_level_i),
    .irq_heti_i      (irq_heti_i),
    .irq_nest_i      (irq_nest_i),
`ifdef HETIC_NEST_CTRL_THRESH_EN
    .thresh_i        (thresh_i),
`endif
    .irq_ack_o       (irq_ack_o),
    .irq_ack_id_o    (irq_ack_id_o),
    .core_irq_valid_o(core_irq_valid_o),
    .core_irq_id_o   (core_irq_id_o),
    .core_irq_heti_o (core_irq_heti_o),
    .core_irq_level_o(core_irq_level_o),
    .core_irq_ready_i(core_irq_ready_i),
    .core_mret_i     (core_mret_i),
    .cur_level_o     (cur_level_o),
    .depth_o         (depth_o),
    .err_o           (err_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int cyc;
    int id;
    int level;
    int heti;
  } offer_t;

  typedef struct {
    int cyc;
    int id;
  } ack_t;

  offer_t exp_offer_q[$];
  ack_t   exp_ack_q[$];

  // Reference model: running level/nest, a frame stack, and the pending offer.
  int m_cur, m_nest, m_err;
  int m_stk_lvl[$];
  int m_stk_nest[$];
  int m_busy;      // 0 free, 1 offer outstanding, 2 claim cycle
  int m_off_id, m_off_lvl, m_off_nest;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_cur = 0;
    m_nest = 0;
    m_err = 0;
    m_stk_lvl.delete();
    m_stk_nest.delete();
    m_busy = 0;
    exp_offer_q.delete();
    exp_ack_q.delete();
  endtask

  task automatic model_eval();
    int thr;
    bit q;
    bit do_push;
    offer_t o;
    ack_t a;
    thr = 0;
`ifdef HETIC_NEST_CTRL_THRESH_EN
    thr = int'(thresh_i);
`endif
    do_push = 1'b0;
    q = irq_valid_i && (int'(irq_level_i) > m_cur) && (int'(irq_level_i) > thr) &&
        (m_stk_lvl.size() == 0 || (m_nest == 1 && m_stk_lvl.size() < StackDepth));
    if (m_busy == 0) begin
      if (q) begin
        m_off_id = int'(irq_id_i);
        m_off_lvl = int'(irq_level_i);
        m_off_nest = int'(irq_nest_i);
        o.cyc = cyc; o.id = m_off_id; o.level = m_off_lvl; o.heti = int'(irq_heti_i);
        exp_offer_q.push_back(o);
        m_busy = 1;
      end
    end else if (m_busy == 1) begin
      if (core_irq_ready_i) begin
        a.cyc = cyc; a.id = m_off_id;
        exp_ack_q.push_back(a);
        do_push = 1'b1;
        m_busy = 2;
      end
    end else begin
      m_busy = 0;
    end
    if (core_mret_i) begin
      if (m_stk_lvl.size() > 0) begin
        m_cur = m_stk_lvl.pop_back();
        m_nest = m_stk_nest.pop_back();
      end else begin
        m_err = 1;
      end
    end
    if (do_push) begin
      if (m_stk_lvl.size() == StackDepth) begin
        m_err = 1;
      end else begin
        m_stk_lvl.push_back(m_cur);
        m_stk_nest.push_back(m_nest);
        m_cur = m_off_lvl;
        m_nest = m_off_nest;
      end
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    cyc++;
    model_eval();
    @(negedge clk_i);
    chk("cur_level", int'(cur_level_o), m_cur);
    chk("depth", int'(depth_o), m_stk_lvl.size());
    chk("err", int'(err_o), m_err);
  endtask

  task automatic drive(input int v, input int id, input int lvl, input int heti,
                       input int nest, input int rdy, input int mret);
    irq_valid_i = v[0];
    irq_id_i = IW'(id);
    irq_level_i = PW'(lvl);
    irq_heti_i = heti[0];
    irq_nest_i = nest[0];
    core_irq_ready_i = rdy[0];
    core_mret_i = mret[0];
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ack"}, int'(irq_ack_o), 0);
    chk({tag, "_ack_id"}, int'(irq_ack_id_o), 0);
    chk({tag, "_valid"}, int'(core_irq_valid_o), 0);
    chk({tag, "_id"}, int'(core_irq_id_o), 0);
    chk({tag, "_heti"}, int'(core_irq_heti_o), 0);
    chk({tag, "_level"}, int'(core_irq_level_o), 0);
    chk({tag, "_cur_level"}, int'(cur_level_o), 0);
    chk({tag, "_depth"}, int'(depth_o), 0);
    chk({tag, "_err"}, int'(err_o), 0);
  endtask

  // Offer id/level/nest, accept it on the next cycle, then let the claim cycle pass.
  task automatic serve(input int id, input int lvl, input int nest);
    drive(1, id, lvl, 0, nest, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0);
    idle(1);
  endtask

  // Monitor: pops expectations whenever the DUT presents an offer or a claim.
  initial begin : monitor
    logic prev_v;
    int h_id, h_lvl, h_heti;
    offer_t e;
    ack_t a;
    prev_v = 1'b0;
    h_id = 0; h_lvl = 0; h_heti = 0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        prev_v = 1'b0;
      end else begin
        if (core_irq_valid_o && !prev_v) begin
          if (exp_offer_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_offer: got id %0d level %0d, expected no offer (cycle %0d)",
                     core_irq_id_o, core_irq_level_o, cyc);
            h_id = int'(core_irq_id_o); h_lvl = int'(core_irq_level_o); h_heti = int'(core_irq_heti_o);
          end else begin
            e = exp_offer_q.pop_front();
            chk("offer_cycle", cyc, e.cyc);
            chk("offer_id", int'(core_irq_id_o), e.id);
            chk("offer_level", int'(core_irq_level_o), e.level);
            chk("offer_heti", int'(core_irq_heti_o), e.heti);
            h_id = e.id; h_lvl = e.level; h_heti = e.heti;
          end
        end else if (core_irq_valid_o) begin
          chk("offer_hold_id", int'(core_irq_id_o), h_id);
          chk("offer_hold_level", int'(core_irq_level_o), h_lvl);
          chk("offer_hold_heti", int'(core_irq_heti_o), h_heti);
        end
        if (irq_ack_o) begin
          if (exp_ack_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_ack: got id %0d, expected no claim (cycle %0d)", irq_ack_id_o, cyc);
          end else begin
            a = exp_ack_q.pop_front();
            chk("ack_cycle", cyc, a.cyc);
            chk("ack_id", int'(irq_ack_id_o), a.id);
          end
        end
        prev_v = core_irq_valid_o;
      end
    end
  end

  initial begin : stimulus
    model_reset();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check_zero("reset");
    rst_ni = 1'b1;

    // Basic offer, accept and claim.
    serve(5, 3, 0);
    chk("t1_cur_level", int'(cur_level_o), 3);
    chk("t1_depth", int'(depth_o), 1);

    // Non-nestable handler blocks a higher level until mret.
    for (int i = 0; i < 3; i++) drive(1, 9, 7, 0, 0, 0, 0);
    drive(1, 9, 7, 0, 0, 0, 1);
    chk("t2_cur_level", int'(cur_level_o), 0);
    drive(1, 9, 7, 0, 0, 0, 0);
    chk("t2_offer_valid", int'(core_irq_valid_o), 1);
    chk("t2_offer_id", int'(core_irq_id_o), 9);
    drive(0, 0, 0, 0, 0, 1, 0);
    idle(1);
    drive(0, 0, 0, 0, 0, 0, 1);
    idle(1);

    // Nest chain up to full depth.
    serve(1, 2, 1);
    serve(2, 4, 1);
    serve(3, 6, 1);
    serve(4, 8, 1);
    chk("t3_depth_full", int'(depth_o), 4);
    for (int i = 0; i < 3; i++) drive(1, 10, 10, 0, 1, 0, 0);
    chk("t3_no_offer", int'(core_irq_valid_o), 0);
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("t3_pop1", int'(cur_level_o), 6);
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("t3_pop2", int'(cur_level_o), 4);
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("t3_pop3", int'(cur_level_o), 2);
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("t3_pop4", int'(cur_level_o), 0);
    chk("t3_err", int'(err_o), 0);
    idle(1);

    // Offer held stable while the arbiter output wanders.
    drive(1, 11, 5, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++)
      drive(int'($urandom_range(1)), int'($urandom_range(63)), int'($urandom_range(31)),
            int'($urandom_range(1)), 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0);
    chk("t4_ack", int'(irq_ack_o), 1);
    chk("t4_ack_id", int'(irq_ack_id_o), 11);
    idle(1);
    drive(0, 0, 0, 0, 0, 0, 1);
    idle(1);

    // mret underflow, then mret coinciding with accept.
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("t5_err", int'(err_o), 1);
    chk("t5_cur_level", int'(cur_level_o), 0);
    idle(2);
    chk("t5_err_sticky", int'(err_o), 1);
    serve(12, 3, 1);
    drive(1, 13, 5, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 1);
    chk("t5_same_depth", int'(depth_o), 1);
    chk("t5_same_level", int'(cur_level_o), 5);
    idle(1);
    drive(0, 0, 0, 0, 0, 0, 1);
    idle(1);

`ifdef HETIC_NEST_CTRL_THRESH_EN
    thresh_i = PW'(4);
    for (int i = 0; i < 3; i++) drive(1, 14, 4, 0, 0, 0, 0);
    chk("t6_below_thresh", int'(core_irq_valid_o), 0);
    drive(1, 15, 5, 0, 0, 0, 0);
    chk("t6_above_thresh", int'(core_irq_valid_o), 1);
    thresh_i = PW'(20);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("t6_thresh_no_withdraw", int'(core_irq_valid_o), 1);
    drive(0, 0, 0, 0, 0, 1, 0);
    idle(1);
    drive(0, 0, 0, 0, 0, 0, 1);
    thresh_i = '0;
    idle(1);
`endif

    // Asynchronous reset in the middle of an offer.
    drive(1, 20, 6, 1, 0, 0, 0);
    #2;
    rst_ni = 1'b0;
    #1;
    check_zero("async_rst");
    irq_valid_i = 1'b0;
    core_irq_ready_i = 1'b1;
    model_reset();
    repeat (3) @(negedge clk_i);
    core_irq_ready_i = 1'b0;
    rst_ni = 1'b1;
    idle(4);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++)
      drive(int'($urandom_range(3) != 0), int'($urandom_range(63)), int'($urandom_range(31)),
            int'($urandom_range(1)), int'($urandom_range(1)),
            int'($urandom_range(2) == 0), int'($urandom_range(7) == 0));
    idle(4);

    chk("offers_left", exp_offer_q.size(), 0);
    chk("acks_left", exp_ack_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
